// File: rtl/load_store_unit.sv
// load_store_unit: sequences RV32I byte/half/word loads and stores onto a
// word-addressed memory with combinational read and synchronous word write.
// Sub-word stores are done as read-modify-write because the memory has no
// byte enables. Misaligned or illegal requests complete with resp_error set
// and never touch memory.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH+1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   merge_q;
  logic [2:0]              funct3_q;

  logic                    req_illegal;
  logic                    req_misaligned;
  logic [7:0]              lane_byte;
  logic [15:0]             lane_half;
  logic [DATA_WIDTH-1:0]   load_data;
  logic [DATA_WIDTH-1:0]   merge_data;

  // Address bits above the memory range are intentionally dropped (4 KB wrap).
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign mem_addr  = addr_q[ADDR_WIDTH+1:2];
  assign mem_write = (state == WRITE);
  assign mem_wdata = (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;

  // Classify an incoming request as illegal funct3 or misaligned.
  always_comb begin
    if (req_we)
      req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    req_misaligned = (((req_funct3 == 3'b001) || (req_funct3 == 3'b101)) && req_addr[0]) ||
                     ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  end

  // Select the byte and halfword lanes addressed by the latched request.
  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      2'd3:    lane_byte = mem_rdata[31:24];
      default: lane_byte = mem_rdata[7:0];
    endcase
    lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Sign- or zero-extend the selected lane according to the load type.
  always_comb begin
    load_data = mem_rdata;
    case (funct3_q)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'h000000, lane_byte};
      3'b101:  load_data = {16'h0000, lane_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Splice the store data into the current memory word for SB/SH.
  always_comb begin
    merge_data = mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merge_data[7:0]   = wdata_q[7:0];
        2'd1:    merge_data[15:8]  = wdata_q[7:0];
        2'd2:    merge_data[23:16] = wdata_q[7:0];
        default: merge_data[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_data[31:16] = wdata_q[15:0];
    end else begin
      merge_data[15:0] = wdata_q[15:0];
    end
  end

  // Request sequencer with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      funct3_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr[ADDR_WIDTH+1:0];
            wdata_q    <= req_wdata;
            funct3_q   <= req_funct3;
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            if (req_illegal || req_misaligned) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (req_funct3[1:0] == 2'b10) begin
              state <= WRITE;
            end else begin
              state <= MERGE;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          state      <= DONE;
        end
        MERGE: begin
          merge_q <= merge_data;
          state   <= WRITE;
        end
        WRITE: begin
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          state      <= DONE;
        end
        DONE: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit. A reference model
// computes each request's outcome from the RV32I load/store rules against a
// shadow copy of memory; monitors compare responses and memory writes.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [9:0]  mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } resp_exp_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  resp_exp_t   resp_q[$];
  wr_exp_t     wr_q[$];
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        preload;
  int          cyc;
  int          n_checks;
  int          n_pass;
  int          last_acc;
  int          prev_acc;

  function automatic logic [31:0] initWord(input int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  // 10 ns clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read, synchronous word write.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= initWord(i);
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Reference model: work out the architectural result of one request.
  task automatic modelRequest(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int acc);
    resp_exp_t   r;
    wr_exp_t     w;
    logic [9:0]  idx;
    int          off;
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    logic        illegal;
    logic        misaligned;
    idx  = addr[11:2];
    off  = int'(addr[1:0]);
    word = ref_mem[idx];
    b    = 8'((word >> (8 * off)) & 32'hFF);
    h    = 16'((word >> (16 * (off / 2))) & 32'hFFFF);
    illegal    = we ? !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                    : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    misaligned = ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) || (f3 == 3'd2 && off != 0);
    r.acc   = acc;
    r.rdata = 32'h0;
    r.err   = illegal || misaligned;
    if (r.err) begin
      r.lat = 1;
    end else if (!we) begin
      r.lat = 2;
      case (f3)
        3'd0:    r.rdata = 32'($signed(b));
        3'd1:    r.rdata = 32'($signed(h));
        3'd4:    r.rdata = {24'h0, b};
        3'd5:    r.rdata = {16'h0, h};
        default: r.rdata = word;
      endcase
    end else begin
      if (f3 == 3'd2) begin
        r.lat = 2;
        w.data = wdata;
      end else if (f3 == 3'd0) begin
        r.lat = 3;
        w.data = (word & ~(32'hFF << (8 * off))) | ((wdata & 32'hFF) << (8 * off));
      end else begin
        r.lat = 3;
        w.data = (word & ~(32'hFFFF << (8 * off))) | ((wdata & 32'hFFFF) << (8 * off));
      end
      w.addr = idx;
      ref_mem[idx] = w.data;
      wr_q.push_back(w);
    end
    resp_q.push_back(r);
  endtask

  // Present a request and hold it until accepted; req_valid is left high.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit track);
    int waited;
    waited     = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checkOutput("req_ready timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      prev_acc = last_acc;
      last_acc = cyc;
      if (track) modelRequest(we, f3, addr, wdata, cyc);
    end
  endtask

  task automatic idleCycles(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Response monitor: pop expected response whenever the DUT completes one.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (resp_q.size() == 0) begin
        checkOutput("unexpected resp_valid", 32'h1, 32'h0);
      end else begin
        resp_exp_t e;
        e = resp_q.pop_front();
        checkOutput("resp_rdata", resp_rdata, e.rdata);
        checkOutput("resp_error", 32'(resp_error), 32'(e.err));
        checkOutput("resp latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  // Write monitor: every memory write must match an expected store.
  always @(negedge clk) begin
    if (mem_write) begin
      if (wr_q.size() == 0) begin
        checkOutput("unexpected mem_write", 32'h1, 32'h0);
      end else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        checkOutput("mem_addr on write", 32'(mem_addr), 32'(e.addr));
        checkOutput("mem_wdata", mem_wdata, e.data);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic [2:0] legal_f3 [0:7];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
    n_checks = 0; n_pass = 0; cyc = 0; last_acc = 0; prev_acc = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = initWord(i);
    preload = 1'b1;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    @(posedge clk); #1;
    preload = 1'b0;
    checkOutput("reset req_ready", 32'(req_ready), 32'h1);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("reset resp_error", 32'(resp_error), 32'h0);
    checkOutput("reset resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset mem_write", 32'(mem_write), 32'h0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of an SB aborts with no write and no response.
    applyStimulus(1'b1, 3'd0, 32'h21, 32'hAA, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort req_ready", 32'(req_ready), 32'h1);
    checkOutput("abort resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("abort mem_write", 32'(mem_write), 32'h0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort mem_write held", 32'(mem_write), 32'h0);
    end
    rst_n = 1'b1;
    idleCycles(3);
    checkOutput("abort word untouched", mem[8], ref_mem[8]);

    // SW then LW at 0x010.
    applyStimulus(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 1'b1);
    applyStimulus(1'b0, 3'd2, 32'h010, 32'h0, 1'b1);
    idleCycles(3);
    checkOutput("SW word 4", mem[4], 32'hDEADBEEF);

    // SB into 0x11223344, then LB and LBU of the new byte.
    applyStimulus(1'b1, 3'd2, 32'h020, 32'h11223344, 1'b1);
    applyStimulus(1'b1, 3'd0, 32'h021, 32'h000000AA, 1'b1);
    applyStimulus(1'b0, 3'd0, 32'h021, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'd4, 32'h021, 32'h0, 1'b1);
    idleCycles(3);
    checkOutput("SB word 8", mem[8], 32'h1122AA44);

    // SH into 0x11223344, then LH and LHU.
    applyStimulus(1'b1, 3'd2, 32'h020, 32'h11223344, 1'b1);
    applyStimulus(1'b1, 3'd1, 32'h022, 32'h00008001, 1'b1);
    applyStimulus(1'b0, 3'd1, 32'h022, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'd5, 32'h022, 32'h0, 1'b1);
    idleCycles(3);
    checkOutput("SH word 8", mem[8], 32'h80013344);

    // Error cases: misaligned LW, misaligned SH, illegal load funct3.
    applyStimulus(1'b0, 3'd2, 32'h006, 32'h0, 1'b1);
    applyStimulus(1'b1, 3'd1, 32'h003, 32'h0000BEEF, 1'b1);
    applyStimulus(1'b0, 3'd3, 32'h000, 32'h0, 1'b1);
    idleCycles(3);

    // Address wrap and back-to-back acceptance with req_valid held high.
    applyStimulus(1'b1, 3'd2, 32'h1004, 32'hCAFEF00D, 1'b1);
    applyStimulus(1'b0, 3'd2, 32'h0004, 32'h0, 1'b1);
    checkOutput("SW back-to-back spacing", 32'(last_acc - prev_acc), 32'd3);
    idleCycles(3);
    checkOutput("SW wrap word 1", mem[1], 32'hCAFEF00D);

    // Randomized traffic over a small window of words with random upper bits.
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      we   = 1'($urandom_range(0, 1));
      f3   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 7)];
      addr = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      applyStimulus(we, f3, addr, $urandom, 1'b1);
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
    end
    req_valid = 1'b0;

    // Drain outstanding expectations, bounded.
    begin
      int waited;
      waited = 0;
      while ((resp_q.size() != 0 || wr_q.size() != 0) && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("drain pending resp", 32'(resp_q.size()), 32'h0);
      checkOutput("drain pending write", 32'(wr_q.size()), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
